// File: rtl/elu_pkg.sv
// elu_pkg: shared op codes, minterm bit positions and the gate helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package elu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NOT  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XOR  = 3'd5;
  localparam op_t OP_XNOR = 3'd6;
  localparam op_t OP_BUF  = 3'd7;

  // Bit positions inside a 4-bit minterm code.
  localparam int MT_AB   = 3;  // a & b
  localparam int MT_ANB  = 2;  // a & ~b
  localparam int MT_NAB  = 1;  // ~a & b
  localparam int MT_NANB = 0;  // ~a & ~b

  // One channel of the selected gate function.
  function automatic logic apply_op(input op_t op, input logic a, input logic b);
    logic y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = a;  // OP_BUF
    endcase
    return y;
  endfunction

endpackage

// File: rtl/elu_mt_decode.sv
// elu_mt_decode: one-channel minterm code -> (a, b, err) priority decoder.
// Latency: combinational. Backpressure: none.
// Ports: mt_i 4-bit code; a_o/b_o decoded operands; err_o set when code is not one-hot.
module elu_mt_decode
  import elu_pkg::*;
(
  input  logic [3:0] mt_i,
  output logic       a_o,
  output logic       b_o,
  output logic       err_o
);

  // Highest set bit wins: a is set when bit 3 or 2 wins, b when bit 3 or 1 wins.
  // Bit 1 only wins when bit 2 is clear (and bit 3 is already covered).
  assign a_o = mt_i[MT_AB] | mt_i[MT_ANB];
  assign b_o = mt_i[MT_AB] | (~mt_i[MT_ANB] & mt_i[MT_NAB]);

  // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
  logic one_hot;
  assign one_hot = (mt_i != 4'd0) && ((mt_i & (mt_i - 4'd1)) == 4'd0);
  assign err_o   = ~one_hot;

endmodule

// File: rtl/encoder_logic_unit.sv
// encoder_logic_unit: CH-channel minterm decode + selectable gate, 2-stage valid/ready pipe.
// Latency: 2 edges from acceptance to out_valid; 1 beat/cycle; 2 beats in flight.
// Backpressure: in_ready = ~s1_valid | ~out_valid | out_ready (combinational from out_ready).
// Ports: in_valid/in_ready/in_mt/in_op in, out_valid/out_ready/out_y/out_err out,
//        err_clr/err_cnt saturating illegal-beat counter, built only with ELU_ERR_COUNT_EN.
module encoder_logic_unit
  import elu_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*CH-1:0]   in_mt,
  input  logic [2:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH-1:0]     out_y,
  output logic [CH-1:0]     out_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [CH-1:0] dec_a, dec_b, dec_err;

  for (genvar k = 0; k < CH; k++) begin : g_dec
    elu_mt_decode u_dec (
      .mt_i  (in_mt[4*k +: 4]),
      .a_o   (dec_a[k]),
      .b_o   (dec_b[k]),
      .err_o (dec_err[k])
    );
  end

  // Stage registers
  logic          s1_valid_q;
  logic [CH-1:0] s1_a_q, s1_b_q, s1_err_q;
  op_t           s1_op_q;
  logic          out_valid_q;
  logic [CH-1:0] out_y_q, out_err_q;
  logic [CH-1:0] out_y_d;

  logic s1_load, s2_load, accept;

  assign s2_load  = ~out_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid & s1_load;

  always_comb begin
    out_y_d = '0;
    for (int k = 0; k < CH; k++) begin
      out_y_d[k] = apply_op(s1_op_q, s1_a_q[k], s1_b_q[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_err_q   <= '0;
      s1_op_q    <= OP_AND;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      s1_a_q     <= dec_a;
      s1_b_q     <= dec_b;
      s1_err_q   <= dec_err;
      s1_op_q    <= op_t'(in_op);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_err_q   <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      out_y_q     <= out_y_d;
      out_err_q   <= s1_err_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_err   = out_err_q;

`ifdef ELU_ERR_COUNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Clear wins over a same-cycle increment; increment saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && (|dec_err) && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = err_clr ^ accept;
  assign err_cnt = '0;
`endif

endmodule
